// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// States, instruction classes, mux selects and ALU codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_MEM    = 3'd4;
  localparam state_t S_WB     = 3'd5;
  localparam state_t S_MULDIV = 3'd6;
  localparam state_t S_TRAP   = 3'd7;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_LUI,
    CL_MUL
  } iclass_t;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;
  localparam logic [2:0] WB_MUL = 3'd4;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  // Shift-right and add/sub share funct3; funct7[5] picks the variant.
  function automatic logic [3:0] alu_code(
    input logic       f7b5,
    input logic [2:0] f3
  );
    return {f7b5, f3};
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier for the multicycle control unit.
// CTRL_MEXT_EN: accept funct7=0000001 R-type as a muldiv op.
module instr_class_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output iclass_t     o_class,
  output logic [3:0]  o_alu_op,
  output logic        o_alu_b_src,
  output logic        o_illegal
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [14:0] w_unused_fields;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];
  assign w_unused_fields = {i_instr[24:15], i_instr[11:7]};

  // Classify the opcode and screen out encodings the core cannot run
  always_comb begin
    o_class     = CL_R;
    o_alu_op    = ALU_ADD;
    o_alu_b_src = 1'b0;
    o_illegal   = 1'b0;
    unique case (w_opc)
      OP_R: begin
        o_class     = CL_R;
        o_alu_op    = alu_code(w_f7[5], w_f3);
        o_alu_b_src = 1'b1;
        if (w_f7 == 7'b0100000) begin
          o_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
        end else if (w_f7 == 7'b0000001) begin
`ifdef CTRL_MEXT_EN
          o_class     = CL_MUL;
          o_alu_op    = ALU_ADD;
          o_alu_b_src = 1'b0;
`else
          o_illegal   = 1'b1;
`endif
        end else if (w_f7 != 7'b0000000) begin
          o_illegal = 1'b1;
        end
      end
      OP_I: begin
        o_class  = CL_I;
        o_alu_op = alu_code((w_f3 == 3'b101) & w_f7[5], w_f3);
      end
      OP_LOAD: begin
        o_class   = CL_LOAD;
        o_illegal = (w_f3 != 3'b010);
      end
      OP_STORE: begin
        o_class   = CL_STORE;
        o_illegal = (w_f3 != 3'b010);
      end
      OP_BRANCH: begin
        o_class     = CL_BRANCH;
        o_alu_op    = ALU_SUB;
        o_alu_b_src = 1'b1;
        o_illegal   = (w_f3[2:1] == 2'b01);
      end
      OP_JAL: o_class = CL_JAL;
      OP_LUI: o_class = CL_LUI;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a bus watchdog.
// CTRL_MEXT_EN: adds the MULDIV state and the mul_start/mul_done handshake.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_W      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  input  logic        mul_done,
  output logic [3:0]  alu_op,
  output logic        alu_b_src,
  output logic        reg_write_en,
  output logic [2:0]  wb_sel,
  output logic        ir_write_en,
  output logic        pc_write_en,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        mul_start,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [TIMEOUT_W-1:0] WD_LIM =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_cause;
  logic [1:0]           w_next_cause;
  logic [TIMEOUT_W-1:0] r_wd_cnt;

  iclass_t    w_class;
  logic [3:0] w_alu_op;
  logic       w_alu_b_src;
  logic       w_illegal;
  logic       w_wait;
  logic       w_timeout;
  logic       w_mul_start;

`ifndef CTRL_MEXT_EN
  logic w_unused_mul_done;
  assign w_unused_mul_done = mul_done;
`endif

  instr_class_decode u_dec (
    .i_instr     (instr),
    .o_class     (w_class),
    .o_alu_op    (w_alu_op),
    .o_alu_b_src (w_alu_b_src),
    .o_illegal   (w_illegal)
  );

  // A stalled request hits the limit on its TIMEOUT_CYCLES-th idle cycle
  assign w_wait    = mem_req & ~mem_ready;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_wait &&
                     (r_wd_cnt == WD_LIM);

  // Next-state and trap-cause selection
  always_comb begin
    w_next       = r_state;
    w_next_cause = r_cause;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_next_cause = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_next       = S_TRAP;
          w_next_cause = TC_ILLEGAL;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (w_class)
          CL_LOAD, CL_STORE: w_next = S_MEM;
          CL_BRANCH:         w_next = S_FETCH;
`ifdef CTRL_MEXT_EN
          CL_MUL:            w_next = S_MULDIV;
`endif
          default:           w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next = (w_class == CL_STORE) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_next_cause = TC_TIMEOUT;
        end
      end
      S_WB: w_next = S_FETCH;
`ifdef CTRL_MEXT_EN
      S_MULDIV: if (mul_done) w_next = S_WB;
`endif
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  // State and sticky trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cause <= TC_NONE;
    end else begin
      r_state <= w_next;
      r_cause <= w_next_cause;
    end
  end

  // Watchdog: run only while a request stalls within one state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_wait || (w_next != r_state)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    alu_op       = ALU_ADD;
    alu_b_src    = 1'b0;
    reg_write_en = 1'b0;
    wb_sel       = WB_ALU;
    ir_write_en  = 1'b0;
    pc_write_en  = 1'b0;
    pc_src       = PC_PLUS4;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    w_mul_start  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req     = 1'b1;
        ir_write_en = mem_ready;
      end
      S_EXEC: begin
        alu_op    = w_alu_op;
        alu_b_src = w_alu_b_src;
        if (w_class == CL_BRANCH) begin
          pc_write_en = 1'b1;
          pc_src      = branch_taken ? PC_BRANCH : PC_PLUS4;
        end
`ifdef CTRL_MEXT_EN
        if (w_class == CL_MUL) w_mul_start = 1'b1;
`endif
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (w_class == CL_STORE);
        if ((w_class == CL_STORE) && mem_ready) begin
          pc_write_en = 1'b1;
          pc_src      = PC_PLUS4;
        end
      end
      S_WB: begin
        reg_write_en = |instr[11:7];
        pc_write_en  = 1'b1;
        pc_src       = (w_class == CL_JAL) ? PC_JAL : PC_PLUS4;
        unique case (w_class)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL:  wb_sel = WB_PC4;
          CL_LUI:  wb_sel = WB_IMM;
`ifdef CTRL_MEXT_EN
          CL_MUL:  wb_sel = WB_MUL;
`endif
          default: wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  assign mul_start  = w_mul_start;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Directed plan sequences followed by randomized instruction streams.
module tb_multicycle_control_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mul_done = 1'b0;
  logic [3:0]  alu_op;
  logic        alu_b_src;
  logic        reg_write_en;
  logic [2:0]  wb_sel;
  logic        ir_write_en;
  logic        pc_write_en;
  logic [1:0]  pc_src;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        mul_start;
  logic        trap;
  logic [1:0]  trap_cause;

  typedef struct packed {
    logic [3:0] aop;
    logic       bsrc;
    logic       rwe;
    logic [2:0] wbs;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       req;
    logic       we;
    logic       asel;
    logic       ms;
    logic       trp;
    logic [1:0] cause;
  } ctl_t;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_LUI, K_MUL, K_ILL} kind_t;

  int   checks = 0;
  int   failures = 0;
  bit   trapped = 1'b0;
  ctl_t w_obs;

  multicycle_control_unit #(
    .TIMEOUT_W      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .mul_done     (mul_done),
    .alu_op       (alu_op),
    .alu_b_src    (alu_b_src),
    .reg_write_en (reg_write_en),
    .wb_sel       (wb_sel),
    .ir_write_en  (ir_write_en),
    .pc_write_en  (pc_write_en),
    .pc_src       (pc_src),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .mul_start    (mul_start),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  always #5 clk = ~clk;

  assign w_obs = '{aop: alu_op, bsrc: alu_b_src, rwe: reg_write_en,
                   wbs: wb_sel, irw: ir_write_en, pcw: pc_write_en,
                   pcs: pc_src, req: mem_req, we: mem_we, asel: addr_sel,
                   ms: mul_start, trp: trap, cause: trap_cause};

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, then compare outputs
  task automatic step(string tag, logic [31:0] ir, logic rdy,
                      logic bt, logic md, ctl_t exp);
    @(negedge clk);
    instr = ir;
    mem_ready = rdy;
    branch_taken = bt;
    mul_done = md;
    #1;
    check_eq(tag, 32'(w_obs), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    mul_done = 1'b0;
    #1;
    check_eq("reset", 32'(w_obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("idle", 32'(w_obs), 32'd0);
    trapped = 1'b0;
  endtask

  function automatic kind_t kind_of(logic [31:0] x);
    logic [2:0] f3;
    logic [6:0] f7;
    kind_t k;
    f3 = x[14:12];
    f7 = x[31:25];
    k = K_ILL;
    case (x[6:0])
      7'h33: begin
        if (f7 == 7'h00) k = K_R;
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) k = K_R;
`ifdef CTRL_MEXT_EN
        else if (f7 == 7'h01) k = K_MUL;
`endif
      end
      7'h13: k = K_I;
      7'h03: if (f3 == 3'd2) k = K_LD;
      7'h23: if (f3 == 3'd2) k = K_ST;
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) k = K_BR;
      7'h6F: k = K_JAL;
      7'h37: k = K_LUI;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // Walk one instruction through the reference trace, cycle by cycle
  task automatic run_instr(logic [31:0] x, int fw, int mw,
                           logic bt, int mulw);
    kind_t k;
    ctl_t  e;
    k = kind_of(x);
    for (int i = 0; i < fw; i++) begin
      e = '0;
      if (i == TO) begin
        e.trp = 1'b1; e.cause = 2'd2;
        step("fetch_timeout", $urandom, 1'b0, 1'b0, 1'b0, e);
        trapped = 1'b1;
        return;
      end
      e.req = 1'b1;
      step("fetch_wait", $urandom, 1'b0, 1'b0, 1'b0, e);
    end
    e = '0; e.req = 1'b1; e.irw = 1'b1;
    step("fetch", $urandom, 1'b1, 1'b0, 1'b0, e);
    e = '0;
    step("decode", x, 1'($urandom), 1'($urandom), 1'b0, e);
    if (k == K_ILL) begin
      e = '0; e.trp = 1'b1; e.cause = 2'd1;
      step("trap_illegal", x, 1'($urandom), 1'b0, 1'b0, e);
      step("trap_hold", x, 1'b1, 1'b1, 1'b1, e);
      trapped = 1'b1;
      return;
    end
    e = '0;
    case (k)
      K_R: begin e.aop = {x[30], x[14:12]}; e.bsrc = 1'b1; end
      K_I: e.aop = (x[14:12] == 3'd5) ? {x[30], 3'd5} : {1'b0, x[14:12]};
      K_BR: begin
        e.aop = 4'b1000; e.bsrc = 1'b1; e.pcw = 1'b1;
        e.pcs = bt ? 2'd1 : 2'd0;
      end
      K_MUL: e.ms = 1'b1;
      default: e = '0;
    endcase
    step("exec", x, 1'($urandom), bt, 1'b0, e);
    if (k == K_BR) return;
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i < mw; i++) begin
        e = '0;
        if (i == TO) begin
          e.trp = 1'b1; e.cause = 2'd2;
          step("mem_timeout", x, 1'b0, 1'b0, 1'b0, e);
          trapped = 1'b1;
          return;
        end
        e.req = 1'b1; e.asel = 1'b1; e.we = (k == K_ST);
        step("mem_wait", x, 1'b0, 1'b0, 1'b0, e);
      end
      e = '0; e.req = 1'b1; e.asel = 1'b1; e.we = (k == K_ST);
      if (k == K_ST) e.pcw = 1'b1;
      step("mem", x, 1'b1, 1'b0, 1'b0, e);
      if (k == K_ST) return;
    end
    if (k == K_MUL) begin
      for (int i = 0; i < mulw; i++)
        step("muldiv_wait", x, 1'($urandom), 1'b0, 1'b0, '0);
      step("muldiv_done", x, 1'b0, 1'b0, 1'b1, '0);
    end
    e = '0;
    e.rwe = (x[11:7] != 5'd0);
    e.pcw = 1'b1;
    e.pcs = (k == K_JAL) ? 2'd2 : 2'd0;
    case (k)
      K_LD:  e.wbs = 3'd1;
      K_JAL: e.wbs = 3'd2;
      K_LUI: e.wbs = 3'd3;
      K_MUL: e.wbs = 3'd4;
      default: e.wbs = 3'd0;
    endcase
    step("wb", x, 1'($urandom), 1'b0, 1'b0, e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin
        x[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: x[31:25] = 7'h00;
          1: x[31:25] = 7'h20;
          2: x[31:25] = 7'h01;
          default: ;
        endcase
      end
      2, 3: x[6:0] = 7'h13;
      4: begin
        x[6:0] = 7'h03;
        if ($urandom_range(0, 3) != 0) x[14:12] = 3'd2;
      end
      5: begin
        x[6:0] = 7'h23;
        if ($urandom_range(0, 3) != 0) x[14:12] = 3'd2;
      end
      6: x[6:0] = 7'h63;
      7: x[6:0] = 7'h6F;
      8: x[6:0] = 7'h37;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
    return x;
  endfunction

  initial begin
    ctl_t e;
    do_reset();
    run_instr(32'h00500093, 0, 0, 1'b0, 0);
    run_instr(32'h402081B3, 0, 0, 1'b0, 0);
    run_instr(32'h4030D093, 0, 0, 1'b0, 0);
    run_instr(32'h00812283, 0, 3, 1'b0, 0);
    run_instr(32'h00512623, 0, 0, 1'b0, 0);
    run_instr(32'h00208463, 0, 0, 1'b1, 0);
    run_instr(32'h00208463, 1, 0, 1'b0, 0);
    run_instr(32'h008000EF, 0, 0, 1'b0, 0);
    run_instr(32'h123452B7, 2, 0, 1'b0, 0);
    run_instr(32'h00100013, 0, 0, 1'b0, 0);
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 0);
    do_reset();
    run_instr(32'h022081B3, 0, 0, 1'b0, 5);
    if (trapped) do_reset();
    run_instr(32'h00500093, TO - 1, 0, 1'b0, 0);
    run_instr(32'h00812283, 0, TO - 1, 1'b0, 0);
    run_instr(32'h00500093, TO + 5, 0, 1'b0, 0);
    do_reset();
    run_instr(32'h00812283, 0, TO + 5, 1'b0, 0);
    do_reset();
    e = '0; e.req = 1'b1; e.irw = 1'b1;
    step("fetch", 32'h0, 1'b1, 1'b0, 1'b0, e);
    step("decode", 32'h00812283, 1'b0, 1'b0, 1'b0, '0);
    step("exec", 32'h00812283, 1'b0, 1'b0, 1'b0, '0);
    e = '0; e.req = 1'b1; e.asel = 1'b1;
    step("mem_wait", 32'h00812283, 1'b0, 1'b0, 1'b0, e);
    do_reset();
    for (int n = 0; n < 150; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom), $urandom_range(0, 4));
      if (trapped) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath enables (PC, IR, register file, memory request) and ALU controls, and handshakes with a variable-latency unified memory.
- Covers R, I-ALU, load, store, branch, JAL and LUI, and traps on illegal instructions or a bus timeout.

Parameters:
- TIMEOUT_W, 4, width of the memory-wait watchdog counter.
- TIMEOUT_CYCLES, 15, number of consecutive not-ready cycles while mem_req is high before a trap; 0 disables the watchdog; must fit in TIMEOUT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  IR contents; stable from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  datapath comparison result, valid in EXEC.
- mul_done  in  1  muldiv result ready (ignored unless CTRL_MEXT_EN).
- alu_op  out  4  ALU operation.
- alu_b_src  out  1  1 = rs2, 0 = immediate.
- reg_write_en  out  1  register file write strobe.
- wb_sel  out  3  writeback mux: 0 ALU, 1 MEM, 2 PC+4, 3 IMM, 4 MULDIV.
- ir_write_en  out  1  load IR from memory read data.
- pc_write_en  out  1  update PC.
- pc_src  out  2  0 PC+4, 1 branch target, 2 JAL target.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1.
- addr_sel  out  1  0 = PC, 1 = ALU result.
- mul_start  out  1  one-cycle muldiv launch pulse.
- trap  out  1  sticky halt indicator.
- trap_cause  out  2  0 none, 1 illegal, 2 bus timeout.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; watchdog clears; trap and trap_cause go to 0.
  - All outputs decode from state and are 0 in IDLE.
  - IDLE moves to FETCH on the first clock after rst_n rises.
  - Reset mid-operation abandons any pending memory request immediately.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - Holds until mem_ready. On mem_ready: ir_write_en=1 that cycle, then go to DECODE.
- DECODE (1 cycle):
  - Classifies opcode: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 0110111 LUI.
  - Illegal cases go to TRAP with cause 1:
    - any other opcode;
    - R-type funct7 not 0000000 or 0100000 (sub/sra allowed only with funct3 000/101);
    - branch funct3 010 or 011;
    - load/store funct3 not 010.
- EXEC (1 cycle), alu_op by class:
  - R: alu_op={funct7[5],funct3}, alu_b_src=1.
  - I: alu_op={funct3==101 ? funct7[5] : 0, funct3}, alu_b_src=0.
  - Load/store: alu_op=0000, alu_b_src=0.
  - Branch: alu_op=1000, alu_b_src=1.
- EXEC transitions:
  - R/I/LUI/JAL go to WB.
  - Load/store go to MEM.
  - Branch: pc_write_en=1, pc_src = branch_taken ? 1 : 0, then go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we = store.
  - Holds until mem_ready, then load goes to WB.
  - Store: pc_write_en=1, pc_src=0, then go to FETCH (same cycle as mem_ready).
- WB (1 cycle):
  - reg_write_en=1 unless instr[11:7]==0 (x0 writes suppressed).
  - wb_sel: R/I=0, load=1, JAL=2, LUI=3.
  - pc_write_en=1, pc_src = JAL ? 2 : 0. Then go to FETCH.
- Latency with zero-wait memory: R/I/LUI/JAL 4, load 5, store 4, branch 3 cycles.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on state change.
  - When the count equals TIMEOUT_CYCLES, go to TRAP with cause 2.
  - mem_ready in the same cycle as the limit wins: no trap.
- TRAP: all strobes 0, trap=1, trap_cause held; left only by reset.
- Enable strobes are never asserted outside the states listed above.

Optional Feature:
- Macro CTRL_MEXT_EN.
- Defined:
  - R-type with funct7=0000001 is legal.
  - EXEC pulses mul_start for one cycle and enters MULDIV.
  - MULDIV holds until mul_done, then goes to WB with wb_sel=4.
  - The watchdog does not run in MULDIV.
- Undefined:
  - funct7=0000001 traps as illegal; the MULDIV state is absent.
  - mul_start is tied to 0 and mul_done is unused.

Decomposition:
- Package ctrl_pkg:
  - opcode constants;
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, MULDIV, TRAP);
  - wb_sel, pc_src and trap_cause encodings;
  - ALU op codes (ADD=0000, SUB=1000).
- Sub-module instr_class_decode: combinational; instr -> instruction class, alu_op, alu_b_src, illegal flag.
- The FSM, watchdog and strobe generation stay in the top module.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready always 1 -> IDLE, FETCH, DECODE, EXEC (alu_op=0000, alu_b_src=0), WB (reg_write_en=1, wb_sel=0, pc_write_en=1); next FETCH 4 cycles after the first.
- sub x3,x1,x2 (0x402081B3) then srai x1,x1,3 (0x4030D093) -> EXEC alu_op=1000 then 1101.
- lw x5,8(x2) (0x00812283), MEM mem_ready delayed 3 cycles -> mem_req=1, addr_sel=1, mem_we=0 for 4 cycles; WB wb_sel=1.
- sw x5,12(x2) (0x00512623) -> MEM mem_we=1, no reg_write_en. Then beq (0x00208463) with branch_taken=1 -> pc_src=1, pc_write_en=1 in EXEC; 3 cycles total.
- Fetch 0xFFFFFFFF -> trap=1, cause 1 after DECODE; then hold mem_ready=0 after a fresh reset -> trap cause 2 after 15 wait cycles; mem_ready arriving on cycle 15 -> no trap.
- addi x0,x0,1 (0x00100013) -> WB with reg_write_en=0. With CTRL_MEXT_EN: mul (0x022081B3) -> mul_start pulse, wait 5 cycles for mul_done, then wb_sel=4; without the macro -> trap cause 1.
